// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART types, parity selection and baud divider helper
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   typedef enum logic {
      PARITY_EVEN = 1'b0,
      PARITY_ODD  = 1'b1
   } parity_e;

   localparam parity_e c_rx_parity = PARITY_EVEN;

   // Clocks per oversample tick, rounded half-up.
   function automatic int unsigned uart_div(input int unsigned sysclk_rate,
                                            input int unsigned baud_rate,
                                            input int unsigned oversample);
      int unsigned tick_rate;
      tick_rate = baud_rate * oversample;
      return (sysclk_rate + tick_rate / 2) / tick_rate;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_os_tick_gen.sv
// ============================================================================
// uart_os_tick_gen : oversample tick divider, counts 0..DIV-1, tick at DIV-1
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_os_tick_gen #(
   parameter int unsigned DIV = 63
) (
   input  logic clk,
   input  logic rst,
   input  logic i_enable,
   input  logic i_restart,
   output logic o_tick
);

   localparam int unsigned     c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

   logic [c_cw-1:0] r_cnt;
   logic            w_wrap;

   assign w_wrap = (r_cnt == c_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_restart || !i_enable || w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + c_cw'(1);
      end
   end

   assign o_tick = i_enable && !i_restart && w_wrap;

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// ============================================================================
// uart_rx_frame : UART receive deserializer with valid/ready character output
// Build option UART_RX_MAJORITY_VOTE_EN: 2-of-3 majority sampling per bit.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int unsigned SYSCLK_RATE = 9600000,
   parameter int unsigned BAUD_RATE   = 9600,
   parameter int unsigned DATA_BITS   = 8,
   parameter int unsigned STOP_BITS   = 2,
   parameter int unsigned OVERSAMPLE  = 16
) (
   input  logic                 SysClk,
   input  logic                 Reset,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 RxParityErr,
   output logic                 RxFrameErr,
   output logic                 RxValid,
   input  logic                 RxReady,
   output logic                 RxOverrun,
   output logic                 RxBusy
);

   localparam int unsigned      c_div        = uart_div(SYSCLK_RATE, BAUD_RATE, OVERSAMPLE);
   localparam int unsigned      c_osw        = $clog2(OVERSAMPLE);
   localparam logic [c_osw-1:0] c_os_last    = c_osw'(OVERSAMPLE - 1);
   localparam logic [3:0]       c_data_last  = 4'(DATA_BITS - 1);
   localparam logic [3:0]       c_stop_last  = 4'(STOP_BITS - 1);
   localparam logic             c_parity_inv = (c_rx_parity == PARITY_ODD);

   localparam logic [2:0] c_st_idle   = RX_IDLE;
   localparam logic [2:0] c_st_start  = RX_START;
   localparam logic [2:0] c_st_data   = RX_DATA;
   localparam logic [2:0] c_st_parity = RX_PARITY;
   localparam logic [2:0] c_st_stop   = RX_STOP;

   logic                 r_rx_meta;
   logic                 r_rx_sync;
   logic                 r_rx_prev;
   logic [2:0]           r_state;
   logic [c_osw-1:0]     r_os_cnt;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_perr_acc;
   logic                 r_ferr_acc;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_perr;
   logic                 r_ferr;
   logic                 r_valid;
   logic                 r_overrun;

   logic                 w_fall;
   logic                 w_start;
   logic                 w_tick;
   logic                 w_sample;
   logic                 w_bit;
   logic                 w_last_stop;
   logic                 w_perr;
   logic                 w_ferr_next;
   logic [DATA_BITS-1:0] w_shift_next;

   always_ff @(posedge SysClk or posedge Reset) begin
      if (Reset) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= Rx;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   // Edge tracking runs in every state, so a line held low after a break
   // must go high again before the next start is recognised.
   assign w_fall  = r_rx_prev & ~r_rx_sync;
   assign w_start = (r_state == c_st_idle) && w_fall;

   uart_os_tick_gen #(
      .DIV (c_div)
   ) u_tick (
      .clk       (SysClk),
      .rst       (Reset),
      .i_enable  (r_state != c_st_idle),
      .i_restart (w_start),
      .o_tick    (w_tick)
   );

   always_ff @(posedge SysClk or posedge Reset) begin
      if (Reset) begin
         r_os_cnt <= '0;
      end else if (r_state == c_st_idle) begin
         r_os_cnt <= '0;
      end else if (w_tick) begin
         r_os_cnt <= (r_os_cnt == c_os_last) ? '0 : r_os_cnt + c_osw'(1);
      end
   end

`ifdef UART_RX_MAJORITY_VOTE_EN
   localparam logic [c_osw-1:0] c_decide = c_osw'(OVERSAMPLE / 2);

   logic r_s0;
   logic r_s1;

   always_ff @(posedge SysClk or posedge Reset) begin
      if (Reset) begin
         r_s0 <= 1'b1;
         r_s1 <= 1'b1;
      end else if (w_tick) begin
         if (r_os_cnt == c_decide - c_osw'(2)) r_s0 <= r_rx_sync;
         if (r_os_cnt == c_decide - c_osw'(1)) r_s1 <= r_rx_sync;
      end
   end

   assign w_bit = (r_s0 & r_s1) | (r_s0 & r_rx_sync) | (r_s1 & r_rx_sync);
`else
   localparam logic [c_osw-1:0] c_decide = c_osw'(OVERSAMPLE / 2 - 1);

   assign w_bit = r_rx_sync;
`endif

   assign w_sample     = w_tick && (r_os_cnt == c_decide);
   assign w_shift_next = DATA_BITS'({w_bit, r_shift} >> 1);
   assign w_perr       = (^r_shift) ^ w_bit ^ c_parity_inv;
   assign w_ferr_next  = r_ferr_acc | ~w_bit;
   assign w_last_stop  = w_sample && (r_state == c_st_stop) && (r_bit_cnt == c_stop_last);

   always_ff @(posedge SysClk or posedge Reset) begin
      if (Reset) begin
         r_state    <= c_st_idle;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_perr_acc <= 1'b0;
         r_ferr_acc <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               r_bit_cnt  <= '0;
               r_ferr_acc <= 1'b0;
               if (w_fall) r_state <= c_st_start;
            end
            c_st_start: begin
               if (w_sample) r_state <= w_bit ? c_st_idle : c_st_data;
            end
            c_st_data: begin
               if (w_sample) begin
                  r_shift <= w_shift_next;
                  if (r_bit_cnt == c_data_last) begin
                     r_bit_cnt <= '0;
                     r_state   <= c_st_parity;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            c_st_parity: begin
               if (w_sample) begin
                  r_perr_acc <= w_perr;
                  r_state    <= c_st_stop;
               end
            end
            c_st_stop: begin
               if (w_sample) begin
                  r_ferr_acc <= w_ferr_next;
                  if (r_bit_cnt == c_stop_last) begin
                     r_bit_cnt <= '0;
                     r_state   <= c_st_idle;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   // A held character is only replaced if it is being accepted this cycle.
   always_ff @(posedge SysClk or posedge Reset) begin
      if (Reset) begin
         r_data    <= '0;
         r_perr    <= 1'b0;
         r_ferr    <= 1'b0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_last_stop) begin
            if (!r_valid || RxReady) begin
               r_data  <= r_shift;
               r_perr  <= r_perr_acc;
               r_ferr  <= w_ferr_next;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && RxReady) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign RxData      = r_data;
   assign RxParityErr = r_perr;
   assign RxFrameErr  = r_ferr;
   assign RxValid     = r_valid;
   assign RxOverrun   = r_overrun;
   assign RxBusy      = (r_state != c_st_idle);

endmodule

`default_nettype wire
